stk_pipe_rsp_q: RTL and testbench
=================================

// Module: stk_pipe_rsp_q
// PURPOSE
//  Per-engine response queue directly downstream of the writeback stage.
//  Writeback emits at most one response per cycle (one-hot valid, shared dat/status) and has no backpressure.
//  This block buffers each engine's responses in a private FIFO and presents them on an independent valid/ready interface.
//  It raises almost-full toward issue for throttling and flags any overflow.
// PARAMETERS
//  ENGS_N   cfg_pkg::ENGS_N  number of engines; one FIFO per engine
//  DEPTH    4                entries per engine FIFO (power of two, >=2)
//  SLACK    2                in-flight responses between issue and this block; sets almost-full
// PORTS
//  clk              in   1              clock
//  arst_n           in   1              async reset, active low
//  i_rsp_vld        in   ENGS_N         one-hot-or-zero response valid from writeback
//  i_rsp_dat        in   128            response data, shared by all engines
//  i_rsp_status     in   status_t       response status (stk_pkg::status_t), shared
//  o_eng_rsp_vld    out  ENGS_N         per-engine response valid
//  i_eng_rsp_rdy    in   ENGS_N         per-engine response ready
//  o_eng_rsp_dat    out  ENGS_N x 128   per-engine head data
//  o_eng_rsp_status out  ENGS_N x status_t  per-engine head status
//  o_rsp_afull      out  ENGS_N         occupancy >= DEPTH-SLACK; issue must stall engine
//  o_rsp_ovf        out  ENGS_N         sticky: a push was dropped on a full FIFO
// BEHAVIOUR
//  - Reset: all FIFOs empty, rd/wr ptrs 0; o_eng_rsp_vld=0, o_rsp_afull=0, o_rsp_ovf=0.
//  - Dat/status outputs are don't-care while vld=0; they are driven 0 after reset.
//  - Push e: i_rsp_vld[e]=1 writes {status,dat} at wr_ptr[e]. Pop e: o_eng_rsp_vld[e] & i_eng_rsp_rdy[e].
//  - Latency, default build: push in cycle N -> o_eng_rsp_vld[e]=1 in N+1. FIFO is registered, no fall-through.
//  - Valid/ready: once vld=1, vld/dat/status stay stable until the pop. Ready may toggle freely.
//  - Occupancy count per engine, width $clog2(DEPTH+1).
//  - Count update: +1 on push only, -1 on pop only, unchanged on push&pop.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - Full (count==DEPTH) with push and no pop: drop the push and set o_rsp_ovf[e]=1 until reset.
//  - Full with push and pop in the same cycle: accept the push, count stays DEPTH, no ovf.
//  - Empty with pop: impossible, since vld=0. Empty with push: count -> 1.
//  - o_rsp_afull[e] is registered off the next count. It asserts the cycle count reaches DEPTH-SLACK.
//  - Illegal: >1 bit of i_rsp_vld set (assertion fires; behaviour undefined).
//  - Reset mid-operation: queued responses are discarded and ovf is cleared; no output glitch beyond the async clear.
//  - Engines are fully independent; a stalled engine never blocks another.
// CONFIGURATION
//  STK_PIPE_RSP_Q_BYPASS_EN
//   defined: when FIFO e is empty, o_eng_rsp_vld[e] = i_rsp_vld[e] in the same cycle, with dat/status passed through combinationally.
//     If i_eng_rsp_rdy[e]=1 that cycle, the response is consumed and not written.
//     Otherwise it is written normally.
//     Latency 0 when empty. Ordering is preserved because bypass applies only when empty.
//   undefined: 1-cycle registered latency as above.
// STRUCTURE
//  stk_pkg additions:
//   - typedef struct packed {status_t status; logic [127:0] dat;} rsp_t
//   - localparam RSP_Q_DEPTH=4
//   - localparam RSP_Q_SLACK=2
//  Sub-module stk_pipe_rsp_q_fifo:
//   - single-engine FIFO of rsp_t, with count, afull, ovf and bypass logic.
//   - Instantiated ENGS_N times in a generate loop.
//  Top level: fans shared dat/status to each instance; i_rsp_vld[e] is the push for instance e.
//  Assertions (`ifdef SIM): $onehot0(i_rsp_vld); vld stable while !rdy; count<=DEPTH.
// TESTING
//  1. Reset, push eng0 dat=0x1 status=OK, rdy=1 -> vld[0]=1 next cycle with dat=0x1, popped; count back to 0.
//  2. rdy[1]=0, push eng1 x4 (dat 0xA..0xD) -> afull[1]=1 after 2nd push, count=4.
//     Release rdy -> pops 0xA,0xB,0xC,0xD in order.
//  3. eng2 full (4 entries), rdy=0, push 0xE -> dropped, ovf[2]=1 sticky.
//     Repeat the same case with rdy=1 in the push cycle -> accepted, ovf=0.
//  4. Wrap test: eng3 streams 9 pushes with alternating rdy -> data out in order, pointers wrap twice, no loss.
//  5. Mid-stream arst_n pulse with eng0 holding 3 entries -> vld=0, count=0, ovf=0; next push is seen normally.
//  6. BYPASS_EN build, eng0 empty, rdy=1, push 0x55 -> vld[0]=1 and dat=0x55 in the same cycle, FIFO stays empty.
//     Same push with rdy=0 -> entry stored and still presented next cycle.

Source files
------------

// File: rtl/stk_pipe_rsp_q_pkg.sv
// Shared types and sizing for the per-engine response queue.
// Bundles the response status enum, the stored entry layout and default queue geometry.
package stk_pipe_rsp_q_pkg;

  localparam int ENGS_N      = 4;
  localparam int RSP_DAT_W   = 128;
  localparam int RSP_Q_DEPTH = 4;
  localparam int RSP_Q_SLACK = 2;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_ERR    = 2'd1,
    ST_TMO    = 2'd2,
    ST_POISON = 2'd3
  } status_t;

  typedef struct packed {
    status_t                status;
    logic [RSP_DAT_W-1:0]   dat;
  } rsp_t;

endpackage

// File: rtl/stk_pipe_rsp_q_chk.sv
// Top-level input checker: writeback may present at most one engine response per cycle.
`ifdef SIM
module stk_pipe_rsp_q_chk #(
  parameter int ENGS_N = 4
) (
  input logic              clk,
  input logic              arst_n,
  input logic [ENGS_N-1:0] i_rsp_vld
);

  a_onehot0: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(i_rsp_vld));

endmodule
`endif

// File: rtl/stk_pipe_rsp_q_fifo.sv
// Single-engine response FIFO with occupancy count, almost-full, sticky overflow.
// STK_PIPE_RSP_Q_BYPASS_EN enables zero-latency pass-through when the FIFO is empty.
module stk_pipe_rsp_q_fifo
  import stk_pipe_rsp_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_push,
  input  rsp_t i_rsp,
  output logic o_vld,
  input  logic i_rdy,
  output rsp_t o_rsp,
  output logic o_afull,
  output logic o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - SLACK);

  rsp_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_afull;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_rd;
  logic          w_drop;
  logic [CW-1:0] w_cnt_nxt;

  // Head presentation, push acceptance and next occupancy.
  always_comb begin
    w_empty = (r_cnt == {CW{1'b0}});
    w_full  = (r_cnt == FULL_CNT);
`ifdef STK_PIPE_RSP_Q_BYPASS_EN
    o_vld = !w_empty || i_push;
    o_rsp = (w_empty && i_push) ? i_rsp : r_mem[r_rd_ptr];
    w_pop = o_vld && i_rdy;
    w_rd  = w_pop && !w_empty;
    // A bypassed response consumed in the same cycle never touches storage.
    w_wr  = i_push && !(w_empty && i_rdy) && (!w_full || w_pop);
`else
    o_vld = !w_empty;
    o_rsp = r_mem[r_rd_ptr];
    w_pop = o_vld && i_rdy;
    w_rd  = w_pop;
    w_wr  = i_push && (!w_full || w_pop);
`endif
    w_drop = i_push && w_full && !w_pop;
    case ({w_wr, w_rd})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Storage, pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_rsp;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_afull <= (w_cnt_nxt >= AFULL_CNT);
      r_ovf   <= r_ovf || w_drop;
    end
  end

  assign o_afull = r_afull;
  assign o_ovf   = r_ovf;

`ifdef SIM
  stk_pipe_rsp_q_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk    (clk),
    .arst_n (arst_n),
    .i_cnt  (r_cnt),
    .i_vld  (o_vld),
    .i_rdy  (i_rdy),
    .i_rsp  (o_rsp)
  );
`endif

endmodule

// File: rtl/stk_pipe_rsp_q_fifo_chk.sv
// Protocol checker for one engine FIFO: occupancy bound and valid/data hold under backpressure.
`ifdef SIM
module stk_pipe_rsp_q_fifo_chk
  import stk_pipe_rsp_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          arst_n,
  input logic [CW-1:0] i_cnt,
  input logic          i_vld,
  input logic          i_rdy,
  input rsp_t          i_rsp
);

  a_cnt_bound: assert property (@(posedge clk) disable iff (!arst_n)
    i_cnt <= CW'(DEPTH));

  a_hold: assert property (@(posedge clk) disable iff (!arst_n)
    (i_vld && !i_rdy) |=> (i_vld && $stable(i_rsp)));

endmodule
`endif

// File: rtl/stk_pipe_rsp_q.sv
// Per-engine response queue behind writeback: one private FIFO per engine, independent valid/ready.
// Build option STK_PIPE_RSP_Q_BYPASS_EN (see stk_pipe_rsp_q_fifo) gives zero latency when empty.
module stk_pipe_rsp_q #(
  parameter int ENGS_N = stk_pipe_rsp_q_pkg::ENGS_N,
  parameter int DEPTH  = stk_pipe_rsp_q_pkg::RSP_Q_DEPTH,
  parameter int SLACK  = stk_pipe_rsp_q_pkg::RSP_Q_SLACK
) (
  input  logic                                      clk,
  input  logic                                      arst_n,
  input  logic [ENGS_N-1:0]                         i_rsp_vld,
  input  logic [127:0]                              i_rsp_dat,
  input  stk_pipe_rsp_q_pkg::status_t               i_rsp_status,
  output logic [ENGS_N-1:0]                         o_eng_rsp_vld,
  input  logic [ENGS_N-1:0]                         i_eng_rsp_rdy,
  output logic [ENGS_N-1:0][127:0]                  o_eng_rsp_dat,
  output stk_pipe_rsp_q_pkg::status_t [ENGS_N-1:0]  o_eng_rsp_status,
  output logic [ENGS_N-1:0]                         o_rsp_afull,
  output logic [ENGS_N-1:0]                         o_rsp_ovf
);

  stk_pipe_rsp_q_pkg::rsp_t w_rsp_in;

  assign w_rsp_in = '{status: i_rsp_status, dat: i_rsp_dat};

  for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
    stk_pipe_rsp_q_pkg::rsp_t w_rsp_out;

    stk_pipe_rsp_q_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .i_push  (i_rsp_vld[e]),
      .i_rsp   (w_rsp_in),
      .o_vld   (o_eng_rsp_vld[e]),
      .i_rdy   (i_eng_rsp_rdy[e]),
      .o_rsp   (w_rsp_out),
      .o_afull (o_rsp_afull[e]),
      .o_ovf   (o_rsp_ovf[e])
    );

    assign o_eng_rsp_dat[e]    = w_rsp_out.dat;
    assign o_eng_rsp_status[e] = w_rsp_out.status;
  end

`ifdef SIM
  stk_pipe_rsp_q_chk #(.ENGS_N(ENGS_N)) u_chk (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_rsp_vld (i_rsp_vld)
  );
`endif

endmodule

// File: tb/tb_stk_pipe_rsp_q.sv
// Directed bench for stk_pipe_rsp_q with a per-engine scoreboard of expected responses.
module tb_stk_pipe_rsp_q;
  import stk_pipe_rsp_q_pkg::*;

  localparam int E = ENGS_N;
  localparam int D = RSP_Q_DEPTH;
  localparam int S = RSP_Q_SLACK;

  logic                clk    = 1'b0;
  logic                arst_n = 1'b1;
  logic [E-1:0]        i_rsp_vld;
  logic [127:0]        i_rsp_dat;
  status_t             i_rsp_status;
  logic [E-1:0]        o_eng_rsp_vld;
  logic [E-1:0]        i_eng_rsp_rdy;
  logic [E-1:0][127:0] o_eng_rsp_dat;
  status_t [E-1:0]     o_eng_rsp_status;
  logic [E-1:0]        o_rsp_afull;
  logic [E-1:0]        o_rsp_ovf;

  logic [129:0] q [E][$];
  logic [E-1:0] m_ovf;
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stk_pipe_rsp_q dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_rsp_vld        (i_rsp_vld),
    .i_rsp_dat        (i_rsp_dat),
    .i_rsp_status     (i_rsp_status),
    .o_eng_rsp_vld    (o_eng_rsp_vld),
    .i_eng_rsp_rdy    (i_eng_rsp_rdy),
    .o_eng_rsp_dat    (o_eng_rsp_dat),
    .o_eng_rsp_status (o_eng_rsp_status),
    .o_rsp_afull      (o_rsp_afull),
    .o_rsp_ovf        (o_rsp_ovf)
  );

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check presented heads, update the model, then check registered flags.
  task automatic tick();
    logic exp_vld;
    logic consumed;
    #1;
    for (int e = 0; e < E; e++) begin
      consumed = 1'b0;
      exp_vld  = (q[e].size() > 0);
`ifdef STK_PIPE_RSP_Q_BYPASS_EN
      if (i_rsp_vld[e]) exp_vld = 1'b1;
`endif
      check($sformatf("vld[%0d]", e), {129'd0, o_eng_rsp_vld[e]}, {129'd0, exp_vld});
      if (q[e].size() > 0) begin
        check($sformatf("head[%0d]", e), {o_eng_rsp_status[e], o_eng_rsp_dat[e]}, q[e][0]);
        if (i_eng_rsp_rdy[e]) void'(q[e].pop_front());
      end else if (exp_vld) begin
        check($sformatf("byp[%0d]", e), {o_eng_rsp_status[e], o_eng_rsp_dat[e]},
              {i_rsp_status, i_rsp_dat});
        consumed = i_eng_rsp_rdy[e];
      end
      if (i_rsp_vld[e] && !consumed) begin
        if (q[e].size() < D) q[e].push_back({i_rsp_status, i_rsp_dat});
        else m_ovf[e] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int e = 0; e < E; e++) begin
      check($sformatf("afull[%0d]", e), {129'd0, o_rsp_afull[e]}, {129'd0, (q[e].size() >= D - S)});
      check($sformatf("ovf[%0d]", e), {129'd0, o_rsp_ovf[e]}, {129'd0, m_ovf[e]});
    end
  endtask

  task automatic push(input int e, input logic [127:0] d, input status_t st);
    i_rsp_vld    = '0;
    i_rsp_vld[e] = 1'b1;
    i_rsp_dat    = d;
    i_rsp_status = st;
    tick();
    i_rsp_vld    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    for (int e = 0; e < E; e++) begin
      check($sformatf("rst_vld[%0d]", e), {129'd0, o_eng_rsp_vld[e]}, 130'd0);
      check($sformatf("rst_afull[%0d]", e), {129'd0, o_rsp_afull[e]}, 130'd0);
      check($sformatf("rst_ovf[%0d]", e), {129'd0, o_rsp_ovf[e]}, 130'd0);
      check($sformatf("rst_dat[%0d]", e), {o_eng_rsp_status[e], o_eng_rsp_dat[e]}, 130'd0);
      q[e].delete();
    end
    m_ovf = '0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rsp_vld     = '0;
    i_eng_rsp_rdy = '0;
    i_rsp_dat     = 128'd0;
    i_rsp_status  = ST_OK;
    m_ovf         = '0;
    #1;
    do_reset();

    // Single response through engine 0.
    i_eng_rsp_rdy[0] = 1'b1;
    push(0, 128'h1, ST_OK);
    idle(2);

    // Engine 1 fills under backpressure, then drains in order.
    i_eng_rsp_rdy[1] = 1'b0;
    push(1, 128'hA, ST_OK);
    push(1, 128'hB, ST_ERR);
    push(1, 128'hC, ST_OK);
    push(1, 128'hD, ST_TMO);
    idle(1);
    i_eng_rsp_rdy[1] = 1'b1;
    idle(5);

    // Engine 2 full and stalled: extra push is dropped, overflow sticks.
    i_eng_rsp_rdy[2] = 1'b0;
    for (int i = 0; i < D; i++) push(2, 128'h20 + 128'(i), ST_OK);
    push(2, 128'hE, ST_POISON);
    idle(2);

    // Reset with engine 0 holding three entries and engine 2 overflowed.
    i_eng_rsp_rdy[0] = 1'b0;
    push(0, 128'h71, ST_OK);
    push(0, 128'h72, ST_ERR);
    push(0, 128'h73, ST_OK);
    do_reset();
    i_eng_rsp_rdy[0] = 1'b1;
    push(0, 128'h77, ST_OK);
    idle(2);

    // Engine 2 full with a pop in the push cycle: accepted, no overflow.
    for (int i = 0; i < D; i++) push(2, 128'h40 + 128'(i), ST_ERR);
    i_eng_rsp_rdy[2] = 1'b1;
    push(2, 128'h4F, ST_OK);
    idle(6);

    // Engine 3 streams nine responses with alternating ready; pointers wrap twice.
    for (int i = 0; i < 9; i++) begin
      i_eng_rsp_rdy[3] = i[0];
      push(3, 128'h30 + 128'(i), (i % 3 == 0) ? ST_ERR : ST_OK);
      i_eng_rsp_rdy[3] = ~i[0];
      tick();
    end
    i_eng_rsp_rdy[3] = 1'b1;
    idle(6);

`ifdef STK_PIPE_RSP_Q_BYPASS_EN
    // Empty engine 0: consumed in the push cycle, then stored when not ready.
    i_eng_rsp_rdy[0] = 1'b1;
    push(0, 128'h55, ST_OK);
    idle(1);
    i_eng_rsp_rdy[0] = 1'b0;
    push(0, 128'h55, ST_ERR);
    idle(1);
    i_eng_rsp_rdy[0] = 1'b1;
    idle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
